// File: rtl/d5m_gen_pkg.sv
// Shared types and constants for the D5M pixel-side frame generator.
package d5m_gen_pkg;

    localparam int unsigned D5M_PIX_W = 12;

    typedef enum logic [2:0] {
        StIdle,
        StFvLead,
        StLine,
        StHblank,
        StFvTrail,
        StVblank
    } state_e;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/d5m_pattern_src.sv
// Test-pattern pixel source; registers odata so it lines up with the registered lval.
module d5m_pattern_src
    import d5m_gen_pkg::*;
(
    input  logic                 pixclk,
    input  logic                 reset,
    input  logic                 line_active,
    input  logic [D5M_PIX_W-1:0] x,
    input  logic [D5M_PIX_W-1:0] y,
    input  logic [1:0]           pattern,
    input  logic [D5M_PIX_W-1:0] const_val,
    output logic [D5M_PIX_W-1:0] odata
);

    logic [D5M_PIX_W-1:0] pix_d;
    logic [D5M_PIX_W-1:0] pix_q;

    always_comb begin
        pix_d = '0;
        if (line_active) begin
            case (pattern)
                PAT_HRAMP: pix_d = x;
                PAT_VRAMP: pix_d = y;
                PAT_CHECK: pix_d = (x[3] ^ y[3]) ? '1 : '0;
                PAT_CONST: pix_d = const_val;
                default:   pix_d = '0;
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign odata = pix_q;

endmodule

// File: rtl/d5m_frame_gen.sv
// D5M sensor emulator: frame/line timing FSM with registered fval/lval and test-pattern data.
module d5m_frame_gen
    import d5m_gen_pkg::*;
#(
    parameter int unsigned ACTIVE_PIXELS = 640,
    parameter int unsigned ACTIVE_LINES  = 480,
    parameter int unsigned H_BLANK       = 16,
    parameter int unsigned FV_LEAD       = 4,
    parameter int unsigned FV_TRAIL      = 4,
    parameter int unsigned V_BLANK       = 32
) (
    input  logic                 pixclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [D5M_PIX_W-1:0] const_val,
    output logic [D5M_PIX_W-1:0] odata,
    output logic                 ofval,
    output logic                 olval,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count
);

    localparam int unsigned XW     = clog2_min1(ACTIVE_PIXELS);
    localparam int unsigned YW     = clog2_min1(ACTIVE_LINES);
    localparam int unsigned MAX_AB = (H_BLANK > FV_LEAD) ? H_BLANK : FV_LEAD;
    localparam int unsigned MAX_CD = (FV_TRAIL > V_BLANK) ? FV_TRAIL : V_BLANK;
    localparam int unsigned MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = clog2_min1(MAX_PH);

    localparam logic [XW-1:0] X_LAST   = XW'(ACTIVE_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(ACTIVE_LINES - 1);
    localparam logic [CW-1:0] LEAD_END = CW'(FV_LEAD - 1);
    localparam logic [CW-1:0] HB_END   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] TR_END   = CW'(FV_TRAIL - 1);
    localparam logic [CW-1:0] VB_END   = CW'(V_BLANK - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [1:0]           pat_q, pat_d;
    logic [D5M_PIX_W-1:0] const_q, const_d;
    logic                 done_d;
    logic                 line_d;
    logic                 fval_d;

    logic                 ofval_q, olval_q, busy_q, done_q;
    logic [15:0]          count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = '0;
        y_d     = y_q;
        pat_d   = pat_q;
        const_d = const_q;
        unique case (state_q)
            StIdle: begin
                y_d = '0;
                if (enable) begin
                    state_d = StFvLead;
                    cnt_d   = '0;
                    pat_d   = pattern_sel;
                    const_d = const_val;
                end
            end
            StFvLead: begin
                if (cnt_q == LEAD_END) begin
                    state_d = StLine;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLine: begin
                cnt_d = '0;
                if (x_q == X_LAST) begin
                    if (y_q != Y_LAST) begin
                        state_d = StHblank;
                        y_d     = y_q + 1'b1;
                    end else begin
                        state_d = StFvTrail;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            StHblank: begin
                if (cnt_q == HB_END) begin
                    state_d = StLine;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFvTrail: begin
                if (cnt_q == TR_END) begin
                    state_d = StVblank;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVblank: begin
                if (cnt_q == VB_END) begin
                    cnt_d = '0;
                    y_d   = '0;
                    if (enable) begin
                        state_d = StFvLead;
                        pat_d   = pattern_sel;
                        const_d = const_val;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state so they equal a decode of the current state.
    assign line_d = (state_d == StLine);
    assign fval_d = (state_d == StFvLead) || (state_d == StLine) ||
                    (state_d == StHblank) || (state_d == StFvTrail);
    assign done_d = (state_d == StFvTrail) && (cnt_d == TR_END);

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= PAT_HRAMP;
            const_q <= '0;
            ofval_q <= 1'b0;
            olval_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            const_q <= const_d;
            ofval_q <= fval_d;
            olval_q <= line_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
            if (done_d) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    d5m_pattern_src u_pattern_src (
        .pixclk      (pixclk),
        .reset       (reset),
        .line_active (line_d),
        .x           (D5M_PIX_W'(x_d)),
        .y           (D5M_PIX_W'(y_d)),
        .pattern     (pat_q),
        .const_val   (const_q),
        .odata       (odata)
    );

    assign ofval       = ofval_q;
    assign olval       = olval_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_d5m_frame_gen.sv
// Scoreboard bench for d5m_frame_gen: 8x4 frames on one instance, a 16-wide checkerboard on another.
module tb_d5m_frame_gen;

    logic        pixclk;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] const_val;
    logic [11:0] odata;
    logic        ofval, olval, busy, frame_done;
    logic [15:0] frame_count;

    logic        enable_b;
    logic [1:0]  pattern_b;
    logic [11:0] const_b;
    logic [11:0] odata_b;
    logic        ofval_b, olval_b, busy_b, done_b;
    logic [15:0] count_b;

    int checks = 0;
    int errors = 0;

    logic [11:0] pix_q[$];
    logic [11:0] pix16_q[$];
    logic [15:0] fc_q[$];

    d5m_frame_gen #(
        .ACTIVE_PIXELS (8),
        .ACTIVE_LINES  (4),
        .H_BLANK       (3),
        .FV_LEAD       (2),
        .FV_TRAIL      (2),
        .V_BLANK       (5)
    ) u_dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .const_val   (const_val),
        .odata       (odata),
        .ofval       (ofval),
        .olval       (olval),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    d5m_frame_gen #(
        .ACTIVE_PIXELS (16),
        .ACTIVE_LINES  (1),
        .H_BLANK       (3),
        .FV_LEAD       (2),
        .FV_TRAIL      (2),
        .V_BLANK       (5)
    ) u_dut16 (
        .pixclk      (pixclk),
        .reset       (reset),
        .enable      (enable_b),
        .pattern_sel (pattern_b),
        .const_val   (const_b),
        .odata       (odata_b),
        .ofval       (ofval_b),
        .olval       (olval_b),
        .busy        (busy_b),
        .frame_done  (done_b),
        .frame_count (count_b)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [11:0] exp_pix(input int p, input int x, input int y,
                                            input logic [11:0] c);
        case (p)
            0:       return 12'(x);
            1:       return 12'(y);
            2:       return (((x ^ y) & 8) != 0) ? 12'hFFF : 12'h000;
            default: return c;
        endcase
    endfunction

    task automatic push_frame(input int p, input logic [11:0] c, input logic [15:0] fc);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                pix_q.push_back(exp_pix(p, x, y, c));
            end
        end
        fc_q.push_back(fc);
    endtask

    // Monitor for the 8x4 instance: pixels, run lengths, frame_done/frame_count.
    int   cyc = 0;
    int   fv_len, lv_len, low_len, hb_cnt, bursts, last_rise;
    logic fv_prev, lv_prev, lv_seen, idle_seen, rise_valid;

    always @(negedge pixclk) begin
        cyc++;
        if (reset) begin
            fv_prev = 1'b0; lv_prev = 1'b0; lv_seen = 1'b0; idle_seen = 1'b1;
            rise_valid = 1'b0; fv_len = 0; lv_len = 0; low_len = 0; hb_cnt = 0; bursts = 0;
        end else begin
            chk("lval_within_fval", int'(olval & ~ofval), 0);
            if (olval) begin
                chk("pixel_expected", int'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) chk("pixel", int'(odata), int'(pix_q.pop_front()));
            end else begin
                chk("odata_blank", int'(odata), 0);
            end
            if (frame_done) begin
                chk("done_in_trail", int'(ofval & ~olval), 1);
                chk("done_expected", int'(fc_q.size() > 0), 1);
                if (fc_q.size() > 0) chk("frame_count", int'(frame_count), int'(fc_q.pop_front()));
            end
            if (ofval && !fv_prev) begin
                if (rise_valid && !idle_seen) begin
                    chk("vblank_len", low_len, 5);
                    chk("frame_period", cyc - last_rise, 50);
                end
                rise_valid = 1'b1; last_rise = cyc; fv_len = 0; bursts = 0; lv_seen = 1'b0;
            end
            if (ofval) fv_len++;
            if (!ofval && fv_prev) begin
                chk("fval_len", fv_len, 45);
                chk("lval_bursts", bursts, 4);
                low_len = 0; idle_seen = 1'b0;
            end
            if (!ofval) begin
                low_len++;
                if (!busy) idle_seen = 1'b1;
            end
            if (olval && !lv_prev) begin
                if (lv_seen) chk("hblank_len", hb_cnt, 3);
                lv_seen = 1'b1; lv_len = 0; bursts++;
            end
            if (olval) lv_len++;
            if (!olval && lv_prev) begin
                chk("lval_len", lv_len, 8);
                hb_cnt = 0;
            end
            if (ofval && !olval && lv_seen) hb_cnt++;
            fv_prev = ofval;
            lv_prev = olval;
        end
    end

    // Monitor for the 16-wide checkerboard instance.
    always @(negedge pixclk) begin
        if (!reset) begin
            chk("b_lval_within_fval", int'(olval_b & ~ofval_b), 0);
            if (olval_b) begin
                chk("b_pixel_expected", int'(pix16_q.size() > 0), 1);
                if (pix16_q.size() > 0) chk("b_pixel", int'(odata_b), int'(pix16_q.pop_front()));
            end else begin
                chk("b_odata_blank", int'(odata_b), 0);
            end
            if (done_b) chk("b_frame_count", int'(count_b), 1);
        end
    end

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return olval;
            1:       return frame_done;
            2:       return !olval;
            default: return !busy;
        endcase
    endfunction

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic wait_sig(input int sel, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sig_sel(sel) && n < 300);
        chk(name, int'(sig_sel(sel)), 1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; const_val = 12'h000;
        enable_b = 1'b0; pattern_b = 2'd2; const_b = 12'h000;
        repeat (3) step();
        chk("rst_odata", int'(odata), 0);
        chk("rst_ofval", int'(ofval), 0);
        chk("rst_olval", int'(olval), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_count", int'(frame_count), 0);

        // Three back-to-back frames: ramp-x, ramp-y, constant A5C.
        push_frame(0, 12'h000, 16'd1);
        push_frame(1, 12'h000, 16'd2);
        push_frame(3, 12'hA5C, 16'd3);
        for (int i = 0; i < 8; i++) pix16_q.push_back(12'h000);
        for (int i = 0; i < 8; i++) pix16_q.push_back(12'hFFF);

        reset = 1'b0; enable = 1'b1; enable_b = 1'b1;
        step();
        enable_b = 1'b0;
        chk("ofval_first_cycle", int'(ofval), 1);
        chk("busy_first_cycle", int'(busy), 1);

        wait_sig(0, "f1_line");
        pattern_sel = 2'd1;
        wait_sig(1, "f1_done");
        wait_sig(0, "f2_line");
        pattern_sel = 2'd3; const_val = 12'hA5C;
        wait_sig(1, "f2_done");
        wait_sig(0, "f3_line");
        enable = 1'b0; pattern_sel = 2'd0; const_val = 12'h123;
        wait_sig(1, "f3_done");

        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (busy && n < 20);
            chk("busy_fall_after_vblank", n, 6);
        end
        begin
            int hi = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (ofval) hi++;
            end
            chk("no_fval_after_stop", hi, 0);
        end
        chk("frame_count_after_stop", int'(frame_count), 3);

        // Abort a frame with reset during HBLANK, then run one full frame.
        for (int x = 0; x < 8; x++) pix_q.push_back(12'(x));
        pattern_sel = 2'd0; enable = 1'b1;
        wait_sig(0, "abort_line0");
        wait_sig(2, "abort_hblank");
        chk("abort_in_hblank", int'(ofval), 1);
        reset = 1'b1;
        step();
        chk("abort_odata", int'(odata), 0);
        chk("abort_ofval", int'(ofval), 0);
        chk("abort_olval", int'(olval), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_frame_done", int'(frame_done), 0);
        chk("abort_frame_count", int'(frame_count), 0);
        push_frame(1, 12'h000, 16'd1);
        pattern_sel = 2'd1; reset = 1'b0;
        wait_sig(1, "f4_done");
        enable = 1'b0;
        wait_sig(3, "f4_idle");

        chk("pix_left", pix_q.size(), 0);
        chk("pix16_left", pix16_q.size(), 0);
        chk("fc_left", fc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

endmodule
